// File: rtl/strb_pkg.sv
// rtl/strb_pkg.sv - shared constants for the strobe-paced timer tick chain
// Contents: FSM state encoding, default counter width, prescaler count width.
package strb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01
  } state_e;

  localparam int CNT_W_DEF = 8;

  // Width of the upstream prescaler count; kept here so the whole tick chain agrees.
  localparam int PRESC_Q_W = 4;

endpackage

// File: rtl/strb_downcnt.sv
// rtl/strb_downcnt.sv - loadable, enable-gated down-counter with terminal-count flag
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clr           force count to zero (highest priority)
//   load          load load_val
//   load_val      value to load
//   dec           decrement by one (saturates at zero)
//   cnt           current count
//   tc            count is 1: the next decrement reaches terminal count
module strb_downcnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      // Never wraps below zero.
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == W'(1));

endmodule

// File: rtl/strb_timer.sv
// rtl/strb_timer.sv - strobe-paced one-shot/periodic timer with done pulse and sticky irq
// Optional feature macro: STRB_TIMER_OVR_EN (adds sticky ovr output).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   strb          prescaler tick (single-cycle, never back-to-back)
//   start         start / restart (latches load_val and periodic)
//   stop          abort to IDLE, no done
//   periodic      1 = auto-reload, 0 = one-shot (sampled on start)
//   load_val      tick count (sampled on start)
//   irq_clr       clears irq (and ovr)
//   busy          high while running
//   cnt           remaining ticks
//   done          one-cycle terminal-count pulse
//   irq           sticky terminal-count flag
//   ovr           (STRB_TIMER_OVR_EN) sticky missed-event flag
module strb_timer
  import strb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strb,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  input  logic             irq_clr,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             done,
  output logic             irq
`ifdef STRB_TIMER_OVR_EN
  ,
  output logic             ovr
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             per_q, per_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             irq_q, irq_d;

  logic             cnt_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_tc;

  strb_downcnt #(
    .W(CNT_W)
  ) u_downcnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // Priority: stop > start > strb (rst handled in the register block).
  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    per_d        = per_q;
    done_d       = 1'b0;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = load_val;
    cnt_dec      = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else if (start) begin
      reload_d = load_val;
      per_d    = periodic;
      cnt_load = 1'b1;
      if (load_val == '0) begin
        // Zero-length period terminates immediately without entering RUN.
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if ((state_q == ST_RUN) && strb) begin
      if (cnt_tc) begin
        done_d = 1'b1;
        if (per_q) begin
          // Reload directly so the period is exactly load_val strobes.
          cnt_load     = 1'b1;
          cnt_load_val = reload_q;
        end else begin
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end else begin
        cnt_dec = 1'b1;
      end
    end

    busy_d = (state_d == ST_RUN);

    // Set wins over a coincident clear.
    irq_d = irq_q;
    if (done_d) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

`ifdef STRB_TIMER_OVR_EN
  logic ovr_q, ovr_d;

  // A new event while the previous one is still unacknowledged.
  always_comb begin
    ovr_d = ovr_q;
    if (done_d && irq_q && !irq_clr) begin
      ovr_d = 1'b1;
    end else if (irq_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr = ovr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      per_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      per_q    <= per_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_strb_timer.sv
// tb/tb_strb_timer.sv - self-checking bench for strb_timer against a strobe-count reference model
module tb_strb_timer;

  logic       clk;
  logic       rst;
  logic       strb;
  logic       start;
  logic       stop;
  logic       periodic;
  logic [7:0] load_val;
  logic       irq_clr;
  logic       busy;
  logic [7:0] cnt;
  logic       done;
  logic       irq;
  logic       ovr;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: counts strobes consumed since the last start.
  bit m_run;
  int m_ticks;
  int m_reload;
  bit m_per;
  bit m_irq;
  bit m_ovr;
  bit m_done;
  bit prev_strb;

  strb_timer #(
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .strb     (strb),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .load_val (load_val),
    .irq_clr  (irq_clr),
    .busy     (busy),
    .cnt      (cnt),
    .done     (done),
    .irq      (irq)
`ifdef STRB_TIMER_OVR_EN
    ,
    .ovr      (ovr)
`endif
  );

`ifndef STRB_TIMER_OVR_EN
  assign ovr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_cnt();
    if (!m_run) return 0;
    return m_reload - (m_ticks % m_reload);
  endfunction

  task automatic model(input bit i_rst, input bit i_start, input bit i_stop, input bit i_per,
                       input int i_lv, input bit i_strb, input bit i_clr);
    bit old_irq;
    old_irq = m_irq;
    if (i_rst) begin
      m_run = 0; m_ticks = 0; m_reload = 0; m_per = 0;
      m_irq = 0; m_ovr = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (i_stop) begin
        m_run = 0;
      end else if (i_start) begin
        m_reload = i_lv;
        m_per    = i_per;
        m_ticks  = 0;
        if (i_lv == 0) begin
          m_run  = 0;
          m_done = 1;
        end else begin
          m_run = 1;
        end
      end else if (m_run && i_strb) begin
        m_ticks++;
        if (m_ticks % m_reload == 0) begin
          m_done = 1;
          if (!m_per) m_run = 0;
        end
      end
      if (m_done) m_irq = 1;
      else if (i_clr) m_irq = 0;
      if (m_done && old_irq && !i_clr) m_ovr = 1;
      else if (i_clr) m_ovr = 0;
    end
  endtask

  task automatic cyc(input bit i_rst, input bit i_start, input bit i_stop, input bit i_per,
                     input int i_lv, input bit i_strb, input bit i_clr);
    if (prev_strb) i_strb = 0;
    prev_strb = i_strb;
    rst      = i_rst;
    start    = i_start;
    stop     = i_stop;
    periodic = i_per;
    load_val = i_lv[7:0];
    strb     = i_strb;
    irq_clr  = i_clr;
    model(i_rst, i_start, i_stop, i_per, i_lv, i_strb, i_clr);
    @(posedge clk);
    #1;
    chk("busy", busy, m_run);
    chk("cnt", cnt, exp_cnt());
    chk("done", done, m_done);
    chk("irq", irq, m_irq);
`ifdef STRB_TIMER_OVR_EN
    chk("ovr", ovr, m_ovr);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; periodic = 0; load_val = 0; strb = 0; irq_clr = 0;
    prev_strb = 0;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_irq", irq, 0);

    // One-shot, load 3
    cyc(0, 1, 0, 0, 3, 0, 0);
    chk("os_cnt3", cnt, 3);
    for (int s = 0; s < 3; s++) begin
      idle(7);
      tick();
    end
    chk("os_done", done, 1);
    chk("os_busy", busy, 0);
    chk("os_irq", irq, 1);
    idle(1);
    chk("os_done_once", done, 0);

    // Periodic, load 2, six strobes
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 2, 0, 0);
    for (int s = 0; s < 6; s++) begin
      idle(2);
      tick();
      chk("per_done", done, (s % 2 == 1) ? 1 : 0);
    end
    chk("per_busy", busy, 1);
    chk("per_cnt", cnt, 2);

    // Reset mid-RUN at cnt=3
    cyc(0, 1, 0, 0, 5, 0, 0);
    tick(); idle(1); tick();
    chk("mid_cnt3", cnt, 3);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", cnt, 0);
    chk("mid_rst_irq", irq, 0);

    // start+stop together
    cyc(0, 1, 1, 0, 4, 0, 0);
    chk("ss_busy", busy, 0);
    idle(1);
    chk("ss_done", done, 0);

    // strb coinciding with start
    idle(1);
    cyc(0, 1, 0, 0, 6, 1, 0);
    chk("sst_cnt", cnt, 6);

    // Restart at cnt=1 with load 5
    idle(1);
    cyc(0, 1, 0, 0, 2, 0, 0);
    tick(); idle(1);
    chk("rs_cnt1", cnt, 1);
    cyc(0, 1, 0, 0, 5, 1, 0);
    chk("rs_cnt5", cnt, 5);
    chk("rs_nodone", done, 0);
    idle(1);
    chk("rs_nodone2", done, 0);

    // Zero load
    cyc(0, 0, 1, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_irq", irq, 1);
    idle(2);
    chk("z_busy2", busy, 0);

    // irq_clr coinciding with done; overrun
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 1, 1, 0, 0);
    idle(1); tick();
    idle(1); cyc(0, 0, 0, 0, 0, 1, 1);
    chk("ic_done", done, 1);
    chk("ic_irq", irq, 1);
    idle(1); tick();
`ifdef STRB_TIMER_OVR_EN
    chk("ovr_set", ovr, 1);
`endif
    cyc(0, 0, 1, 0, 0, 0, 1);
    chk("clr_irq", irq, 0);
`ifdef STRB_TIMER_OVR_EN
    chk("ovr_clr", ovr, 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit r_rst, r_st, r_sp, r_per, r_sb, r_clr;
      int r_lv;
      r_rst = ($urandom_range(0, 999) < 4);
      r_st  = ($urandom_range(0, 99) < 6);
      r_sp  = ($urandom_range(0, 99) < 2);
      r_per = $urandom_range(0, 1);
      r_sb  = ($urandom_range(0, 99) < 35);
      r_clr = ($urandom_range(0, 99) < 6);
      r_lv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      cyc(r_rst, r_st, r_sp, r_per, r_lv, r_sb, r_clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/strb_timer.md
Name: strb_timer

Overview:
- Programmable strobe-paced timer sitting directly downstream of the prescaler (presc).
- Counts the prescaler's one-clock `strb` pulses down from a loaded value and emits a one-clock `done` pulse plus a sticky `irq` at terminal count.
- Supports one-shot and periodic modes, start/stop control and restart.
- Provides the slow-tick timing base for LED/display sequencing logic.

Parameters:
- CNT_W, 8, width of load value and down-counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- strb  in  1  prescaler tick, exactly one clk cycle wide; never asserted on consecutive cycles.
- start  in  1  level sampled each clk; starts or restarts the timer.
- stop  in  1  level sampled each clk; aborts the timer.
- periodic  in  1  sampled on start only; 1 = auto-reload, 0 = one-shot.
- load_val  in  CNT_W  tick count, sampled on start only.
- irq_clr  in  1  clears irq.
- busy  out  1  high while in RUN.
- cnt  out  CNT_W  current remaining ticks.
- done  out  1  one-clk pulse at terminal count.
- irq  out  1  sticky terminal-count flag.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, cnt=0, reload register=0, periodic latch=0, busy=0, done=0, irq=0. Reset overrides every other input.
- States: IDLE (2'b00), RUN (2'b01). busy = (state==RUN), registered.
- Priority each cycle: rst > stop > start > strb.
- stop=1: state->IDLE, cnt->0, no done. Applies in any state. stop wins over a simultaneous start or strb.
- start=1 with stop=0, in any state:
  - Latch load_val into the reload register and cnt.
  - Latch periodic.
  - state->RUN.
  - A strb in the same cycle is ignored (the count begins on the next strb).
  - Restart while in RUN discards the current count; no done is emitted.
- start with load_val=0: no RUN. done pulses on the next cycle, irq sets, state stays IDLE, cnt=0.
- RUN, strb=1, cnt>1: cnt decrements by 1.
- RUN, strb=1, cnt==1:
  - done=1 on the following clk cycle (registered; 1 cycle latency from the sampled strb).
  - periodic latch=1: cnt->reload value, stay in RUN.
  - periodic latch=0: cnt->0, state->IDLE.
- RUN, strb=0: hold.
- IDLE: strb is ignored; cnt holds.
- done is high for exactly one cycle per terminal count.
- irq: set on the same edge that asserts done. Cleared by irq_clr=1. Set wins if set and clear coincide.
- Arithmetic: unsigned; cnt never decrements below 0 and never wraps.
- Period in periodic mode = load_val strobes exactly (no extra reload tick).

Optional Feature:
- Macro STRB_TIMER_OVR_EN.
- With the macro defined:
  - Adds output ovr (1 bit, sticky).
  - ovr sets when done asserts while irq is already 1 and irq_clr=0 in that cycle (software missed an event).
  - Cleared only by irq_clr or rst; reset value 0.
- Without the macro: ovr port and logic absent; all other behaviour identical.

Decomposition:
- Shared package strb_pkg:
  - state encoding constants ST_IDLE, ST_RUN.
  - default CNT_W.
  - PRESC_Q_W=4 (matches prescaler Qount width), for consistency across the tick chain.
- One natural sub-module: strb_downcnt (loadable, enable-gated down-counter with terminal-count flag). The FSM and irq/ovr flags stay in strb_timer.

Test Plan:
- Reset: hold rst 5 cycles mid-RUN with cnt=3 -> busy=0, cnt=0, done=0, irq=0 on the edge after rst.
- One-shot: start with load_val=3, periodic=0; 3 strbs spaced 8 clk -> cnt 3,2,1,0; done pulses 1 cycle after the 3rd strb; busy falls the same edge; irq=1.
- Periodic: load_val=2, periodic=1, 6 strbs -> done after strbs 2, 4, 6; cnt sequence 2,1,2,1,2,1,2; busy stays 1.
- Simultaneous events:
  - start+stop in the same cycle -> IDLE, no done.
  - strb coinciding with start -> cnt=load_val (not decremented).
  - Restart at cnt=1 with load_val=5 -> cnt=5, no done.
- Zero load: start with load_val=0 -> done 1 cycle later, busy never 1, irq=1.
- irq/ovr: irq_clr and done on the same cycle -> irq stays 1. With STRB_TIMER_OVR_EN, a second done with irq uncleared -> ovr=1; irq_clr -> irq=0 and ovr=0.
